// File: rtl/count_tracker_pkg.sv
// rtl/count_tracker_pkg.sv - shared types and constants for the count tracker
package count_tracker_pkg;

    // Classification of one sample against the previous one
    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        UP      = 3'd1,
        DOWN    = 3'd2,
        RESTART = 3'd3,
        JUMP    = 3'd4
    } step_class_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Run counter width; covers LOCK_CNT values 1..15
    localparam int RUN_W = 4;

endpackage

// File: rtl/count_tracker_if.sv
// rtl/count_tracker_if.sv - sample and status bundle between the observed counter and the tracker
// master: drives en, in, clear_err; observes dir, locked, step_err, dir_change, err_count
// slave : the tracker side of the same bundle
interface count_tracker_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) ();
    logic             en;
    logic [WIDTH-1:0] in;
    logic             clear_err;
    logic             dir;
    logic             locked;
    logic             step_err;
    logic             dir_change;
    logic [ERR_W-1:0] err_count;

    modport master (
        output en, in, clear_err,
        input  dir, locked, step_err, dir_change, err_count
    );

    modport slave (
        input  en, in, clear_err,
        output dir, locked, step_err, dir_change, err_count
    );
endinterface

// File: rtl/count_step_classify.sv
// rtl/count_step_classify.sv - combinational step classifier for one count sample
// Ports: prev (last sampled value), in (current value), cls (step class)
module count_step_classify
    import count_tracker_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] in,
    output step_class_t      cls
);
    logic [WIDTH-1:0] delta;

    // Modular difference makes max->0 an UP and 0->max a DOWN for free
    assign delta = in - prev;

    always_comb begin
        cls = JUMP;
        if (delta == WIDTH'(1))
            cls = UP;
        else if (delta == {WIDTH{1'b1}})
            cls = DOWN;
        else if (delta == '0)
            cls = HOLD;
        else if (in == '0)
            cls = RESTART;
    end
endmodule

// File: rtl/count_tracker.sv
// rtl/count_tracker.sv - direction/lock tracker and step error counter for an up/down counter bus
// Ports: clk, rst (async active-high), bus (slave side: en, in, clear_err in;
//        dir, locked, step_err, dir_change, err_count out; all outputs registered)
module count_tracker
    import count_tracker_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    count_tracker_if.slave        bus
);
    state_t             state_q, state_n;
    logic [WIDTH-1:0]   prev_q, prev_n;
    logic [RUN_W-1:0]   run_q, run_n;
    logic               dir_q, dir_n;
    logic               locked_q;
    logic               step_err_q, step_err_n;
    logic               dir_change_q, dir_change_n;
    logic [ERR_W-1:0]   err_q, err_n;

    step_class_t        cls;
    logic               is_step;
    logic               step_dir;

    count_step_classify #(.WIDTH(WIDTH)) u_classify (
        .prev (prev_q),
        .in   (bus.in),
        .cls  (cls)
    );

    assign is_step  = (cls == UP) || (cls == DOWN);
    assign step_dir = (cls == UP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            prev_q       <= '0;
            run_q        <= '0;
            dir_q        <= 1'b1;
            locked_q     <= 1'b0;
            step_err_q   <= 1'b0;
            dir_change_q <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_n;
            prev_q       <= prev_n;
            run_q        <= run_n;
            dir_q        <= dir_n;
            locked_q     <= (state_n == LOCKED);
            step_err_q   <= step_err_n;
            dir_change_q <= dir_change_n;
            err_q        <= err_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        prev_n       = prev_q;
        run_n        = run_q;
        dir_n        = dir_q;
        step_err_n   = 1'b0;
        dir_change_n = 1'b0;
        err_n        = err_q;

        if (bus.en) begin
            prev_n = bus.in;
            case (state_q)
                EMPTY: begin
                    state_n = ACQUIRE;
                    run_n   = '0;
                end
                ACQUIRE: begin
                    if (is_step) begin
                        // A fresh run (run=0) adopts whatever direction it sees
                        if (run_q != '0 && step_dir == dir_q) begin
                            run_n = run_q + RUN_W'(1);
                        end else begin
                            dir_n = step_dir;
                            run_n = RUN_W'(1);
                        end
                        if (run_n == RUN_W'(LOCK_CNT))
                            state_n = LOCKED;
                    end else if (cls == RESTART || cls == JUMP) begin
                        run_n = '0;
                    end
                end
                LOCKED: begin
                    if (is_step && step_dir != dir_q) begin
                        dir_n        = step_dir;
                        dir_change_n = 1'b1;
                    end else if (cls == RESTART) begin
                        // Counter was reset: re-acquire quietly
                        state_n = ACQUIRE;
                        run_n   = '0;
                    end else if (cls == JUMP) begin
                        step_err_n = 1'b1;
                        if (err_q != {ERR_W{1'b1}})
                            err_n = err_q + ERR_W'(1);
                        state_n = ACQUIRE;
                        run_n   = '0;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    run_n   = '0;
                end
            endcase
        end

        // Clear wins over a same-cycle increment
        if (bus.clear_err)
            err_n = '0;
    end

    assign bus.dir        = dir_q;
    assign bus.locked     = locked_q;
    assign bus.step_err   = step_err_q;
    assign bus.dir_change = dir_change_q;
    assign bus.err_count  = err_q;

endmodule
